dmem_arbiter: RTL and testbench

Shares one single-port data memory between two requesters.
- Port 0: CPU load/store stage.
- Port 1: DMA / debug loader.
Round-robin arbitration with a req/ack handshake toward requesters and an enable/ack handshake toward a multi-cycle memory. Sits between the MEM pipeline stage / DMA engine and the data memory. Includes a timeout watchdog so a missing memory ack cannot hang the pipeline.

---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/dmem_arb_rr.sv | 23 ++
 rtl/dmem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter (dmem_arbiter).
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_TIMEOUT_CYC = 16;

endpackage

// File: rtl/dmem_arb_rr.sv
// Combinational 2-way round-robin picker: on a conflict the port that did
// not win last time is chosen; a sole requester always wins.
module dmem_arb_rr
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       gnt_o,
    output logic       valid_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        valid_o = |req_i;
        gnt_o   = PORT_CPU;
        if (req_i == 2'b11) begin
            gnt_o = ~last_grant_i;
        end else if (req_i[1]) begin
            gnt_o = PORT_DMA;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a multi-cycle single-port data memory,
// with a BUSY-phase timeout watchdog. Define DMEM_ARB_PERF_EN to build perf counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    output logic              ack0_o,
    output logic [DATA_W-1:0] rdata0_o,
    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              ack1_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              err_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [31:0]       perf_grant0_o,
    output logic [31:0]       perf_grant1_o,
    output logic [31:0]       perf_conflict_o
);

    localparam int                CNT_W   = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    state_e              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                rr_gnt, rr_valid;

    dmem_arb_rr u_rr (
        .req_i        ({req1_i, req0_i}),
        .last_grant_i (last_grant_q),
        .gnt_o        (rr_gnt),
        .valid_o      (rr_valid)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        unique case (state_q)
            IDLE: if (rr_valid) begin
                grant_d = rr_gnt;
                we_d    = (rr_gnt == PORT_DMA) ? we1_i    : we0_i;
                addr_d  = (rr_gnt == PORT_DMA) ? addr1_i  : addr0_i;
                wdata_d = (rr_gnt == PORT_DMA) ? wdata1_i : wdata0_i;
                state_d = BUSY;
            end
            BUSY: begin
                // A late ack landing on the expiry cycle still wins over the timeout.
                if (mem_ack_i || cnt_q == CNT_MAX) begin
                    if (grant_q == PORT_DMA) rdata1_d = (we_q || !mem_ack_i) ? '0 : mem_data_i;
                    else                     rdata0_d = (we_q || !mem_ack_i) ? '0 : mem_data_i;
                    err_d   = !mem_ack_i;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                last_grant_d = grant_q;
                cnt_d        = '0;
                err_d        = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            grant_q      <= PORT_CPU;
            last_grant_q <= PORT_DMA;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    // Outputs decode straight from state so reset removes them asynchronously.
    assign mem_enable_o = (state_q == BUSY);
    assign mem_write_o  = we_q;
    assign mem_addr_o   = addr_q;
    assign mem_data_o   = wdata_q;
    assign ack0_o       = (state_q == DONE) && (grant_q == PORT_CPU);
    assign ack1_o       = (state_q == DONE) && (grant_q == PORT_DMA);
    assign err_o        = (state_q == DONE) && err_q;
    assign rdata0_o     = rdata0_q;
    assign rdata1_o     = rdata1_q;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_g0_q, perf_g0_d;
    logic [31:0] perf_g1_q, perf_g1_d;
    logic [31:0] perf_cf_q, perf_cf_d;

    always_comb begin
        perf_g0_d = perf_g0_q;
        perf_g1_d = perf_g1_q;
        perf_cf_d = perf_cf_q;
        if (ack0_o && perf_g0_q != '1) perf_g0_d = perf_g0_q + 32'd1;
        if (ack1_o && perf_g1_q != '1) perf_g1_d = perf_g1_q + 32'd1;
        if (state_q == IDLE && req0_i && req1_i && perf_cf_q != '1) perf_cf_d = perf_cf_q + 32'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_g0_q <= '0;
            perf_g1_q <= '0;
            perf_cf_q <= '0;
        end else begin
            perf_g0_q <= perf_g0_d;
            perf_g1_q <= perf_g1_d;
            perf_cf_q <= perf_cf_d;
        end
    end

    assign perf_grant0_o   = perf_g0_q;
    assign perf_grant1_o   = perf_g1_q;
    assign perf_conflict_o = perf_cf_q;
`else
    assign perf_grant0_o   = '0;
    assign perf_grant1_o   = '0;
    assign perf_conflict_o = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table-driven single transactions plus
// hand-written sequences for spurious ack, mid-BUSY reset and alternation.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req0_i = 1'b0, we0_i = 1'b0, req1_i = 1'b0, we1_i = 1'b0;
    logic [31:0] addr0_i = '0, wdata0_i = '0, addr1_i = '0, wdata1_i = '0;
    logic        ack0_o, ack1_o, err_o;
    logic [31:0] rdata0_o, rdata1_o;
    logic        mem_enable_o, mem_write_o;
    logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
    logic        mem_ack_i;
    logic [31:0] perf_grant0_o, perf_grant1_o, perf_conflict_o;

    always #5 clk_i = ~clk_i;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_i(req0_i), .we0_i(we0_i), .addr0_i(addr0_i), .wdata0_i(wdata0_i),
        .ack0_o(ack0_o), .rdata0_o(rdata0_o),
        .req1_i(req1_i), .we1_i(we1_i), .addr1_i(addr1_i), .wdata1_i(wdata1_i),
        .ack1_o(ack1_o), .rdata1_o(rdata1_o),
        .err_o(err_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .perf_grant0_o(perf_grant0_o), .perf_grant1_o(perf_grant1_o),
        .perf_conflict_o(perf_conflict_o)
    );

    // Memory model: acks in the lat-th consecutive enable cycle (lat=0: never).
    int          lat = 0;
    int          busy_cnt = 0;
    logic [31:0] mem_rd = '0;
    logic        model_ack = 1'b0;
    logic        spur = 1'b0;
    assign mem_data_i = mem_rd;
    assign mem_ack_i  = model_ack | spur;

    always @(negedge clk_i) begin
        if (mem_enable_o) begin
            model_ack <= (busy_cnt == lat - 1);
            busy_cnt  <= busy_cnt + 1;
        end else begin
            model_ack <= 1'b0;
            busy_cnt  <= 0;
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_rd0 = '0, exp_rd1 = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        req0;
        logic        we0;
        logic [31:0] addr0;
        logic [31:0] wdata0;
        logic        req1;
        logic        we1;
        logic [31:0] addr1;
        logic [31:0] wdata1;
        int          lat;
        logic [31:0] mrd;
        logic        exp_port;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[7];

    // Drives one request set from an IDLE negedge, returns at the IDLE negedge after the ack.
    task automatic run_vec(input int idx, input vec_t v);
        int          cyc;
        bit          got, bad;
        logic        e_we;
        logic [31:0] e_a, e_d;
        e_we = v.exp_port ? v.we1    : v.we0;
        e_a  = v.exp_port ? v.addr1  : v.addr0;
        e_d  = v.exp_port ? v.wdata1 : v.wdata0;
        req0_i = v.req0; we0_i = v.we0; addr0_i = v.addr0; wdata0_i = v.wdata0;
        req1_i = v.req1; we1_i = v.we1; addr1_i = v.addr1; wdata1_i = v.wdata1;
        lat = v.lat; mem_rd = v.mrd;
        cyc = 0; got = 0; bad = 0;
        while (!got && cyc < 40) begin
            @(negedge clk_i);
            cyc++;
            if (ack0_o || ack1_o) got = 1;
            else if (!mem_enable_o || mem_write_o !== e_we || mem_addr_o !== e_a ||
                     mem_data_o !== e_d || err_o !== 1'b0) bad = 1;
        end
        check($sformatf("v%0d_busy_fields", idx), 64'(bad), 64'(0));
        check($sformatf("v%0d_ack_cycle", idx), 64'(cyc), 64'(v.exp_cyc));
        check($sformatf("v%0d_acks", idx), 64'({ack1_o, ack0_o}),
              64'(v.exp_port ? 2'b10 : 2'b01));
        check($sformatf("v%0d_err", idx), 64'(err_o), 64'(v.exp_err));
        check($sformatf("v%0d_enable_done", idx), 64'(mem_enable_o), 64'(0));
        if (v.exp_port) exp_rd1 = v.exp_rdata;
        else            exp_rd0 = v.exp_rdata;
        check($sformatf("v%0d_rdata0", idx), 64'(rdata0_o), 64'(exp_rd0));
        check($sformatf("v%0d_rdata1", idx), 64'(rdata1_o), 64'(exp_rd1));
        req0_i = 1'b0; req1_i = 1'b0;
        @(negedge clk_i);
        check($sformatf("v%0d_pulse_end", idx), 64'({ack1_o, ack0_o, err_o, mem_enable_o}), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int          cyc;
        bit          bad;
        logic        exp_p;

        // fields: req0 we0 addr0 wdata0 | req1 we1 addr1 wdata1 | lat mrd | port err rdata cyc
        vecs[0] = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0,
                    1,  32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF, 2};
        vecs[1] = '{1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678,
                    3,  32'hFFFF0000, 1'b1, 1'b0, 32'h0, 4};
        vecs[2] = '{1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0,
                    2,  32'hCAFEF00D, 1'b0, 1'b0, 32'hCAFEF00D, 3};
        vecs[3] = '{1'b1, 1'b1, 32'h50, 32'hA, 1'b1, 1'b0, 32'h60, 32'h0,
                    1,  32'h11112222, 1'b1, 1'b0, 32'h11112222, 2};
        vecs[4] = '{1'b1, 1'b0, 32'h64, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0,
                    0,  32'h99999999, 1'b0, 1'b1, 32'h0, 17};
        vecs[5] = '{1'b1, 1'b0, 32'h68, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0,
                    1,  32'h000055AA, 1'b0, 1'b0, 32'h000055AA, 2};
        vecs[6] = '{1'b1, 1'b0, 32'h74, 32'h0, 1'b1, 1'b1, 32'h70, 32'h77,
                    16, 32'h88888888, 1'b1, 1'b0, 32'h0, 17};

        // Reset state.
        #1;
        check("rst_ctrl", 64'({ack0_o, ack1_o, err_o, mem_enable_o, mem_write_o}), 64'(0));
        check("rst_addr_data", {mem_addr_o, mem_data_o}, 64'(0));
        check("rst_rdata", {rdata0_o, rdata1_o}, 64'(0));
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Spurious ack in IDLE is ignored.
        spur = 1'b1;
        bad = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            if (ack0_o || ack1_o || err_o || mem_enable_o) bad = 1;
        end
        spur = 1'b0;
        check("spurious_ack_idle", 64'(bad), 64'(0));

        // Address change and req drop during BUSY do not disturb the transaction.
        req0_i = 1'b1; we0_i = 1'b0; addr0_i = 32'h80; wdata0_i = 32'h0;
        lat = 3; mem_rd = 32'h13572468;
        @(negedge clk_i);
        addr0_i = 32'h99; req0_i = 1'b0;
        cyc = 1; bad = 0;
        if (mem_addr_o !== 32'h80 || !mem_enable_o) bad = 1;
        while (!(ack0_o || ack1_o) && cyc < 40) begin
            @(negedge clk_i);
            cyc++;
            if (!(ack0_o || ack1_o) && (mem_addr_o !== 32'h80 || !mem_enable_o)) bad = 1;
        end
        check("addr_held_busy", 64'(bad), 64'(0));
        check("dropped_req_ack_cycle", 64'(cyc), 64'(4));
        check("dropped_req_acks", 64'({ack1_o, ack0_o}), 64'(2'b01));
        exp_rd0 = 32'h13572468;
        check("dropped_req_rdata0", 64'(rdata0_o), 64'(exp_rd0));
        @(negedge clk_i);
        check("dropped_req_no_repeat", 64'({ack1_o, ack0_o, mem_enable_o}), 64'(0));

        // Reset asserted mid-BUSY.
        req0_i = 1'b1; addr0_i = 32'h300; lat = 0;
        repeat (3) @(negedge clk_i);
        check("pre_reset_busy", 64'(mem_enable_o), 64'(1));
        rst_i = 1'b1;
        #1;
        check("reset_async_drop", 64'({mem_enable_o, ack0_o, ack1_o, err_o}), 64'(0));
        req0_i = 1'b0;
        exp_rd0 = '0; exp_rd1 = '0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Continuous dual requests alternate 0,1,0,1 starting with port 0, 6 cycles apart.
        req0_i = 1'b1; we0_i = 1'b0; addr0_i = 32'h100;
        req1_i = 1'b1; we1_i = 1'b0; addr1_i = 32'h200;
        lat = 4; mem_rd = 32'h0BADF00D;
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            do begin
                @(negedge clk_i);
                cyc++;
            end while (!(ack0_o || ack1_o) && cyc < 40);
            exp_p = k[0];
            check($sformatf("alt%0d_spacing", k), 64'(cyc), 64'((k == 0) ? 5 : 6));
            check($sformatf("alt%0d_grant", k), 64'({ack1_o, ack0_o}),
                  64'(exp_p ? 2'b10 : 2'b01));
            if (exp_p) exp_rd1 = 32'h0BADF00D;
            else       exp_rd0 = 32'h0BADF00D;
            check($sformatf("alt%0d_rdata", k), {rdata1_o, rdata0_o}, {exp_rd1, exp_rd0});
        end
        req0_i = 1'b0; req1_i = 1'b0;
        @(negedge clk_i);
        check("alt_end_idle", 64'({ack1_o, ack0_o, mem_enable_o}), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
